// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, bubble insertion and flush squash.
// Optional hazard-bubble counter (output bubble_cnt) is enabled by defining ID_EX_PERF_CNT_EN.
module id_ex_stage #(
    parameter int XLEN = 64,
    parameter int RAW  = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            id_valid,
    input  logic            id_alusrc,
    input  logic            id_memtoreg,
    input  logic            id_regwrite,
    input  logic            id_memread,
    input  logic            id_memwrite,
    input  logic            id_branch,
    input  logic            id_aluop1,
    input  logic            id_aluop0,
    input  logic [XLEN-1:0] id_pc,
    input  logic [XLEN-1:0] id_rs1_data,
    input  logic [XLEN-1:0] id_rs2_data,
    input  logic [XLEN-1:0] id_imm,
    input  logic [RAW-1:0]  id_rs1,
    input  logic [RAW-1:0]  id_rs2,
    input  logic [RAW-1:0]  id_rd,
    input  logic [2:0]      id_funct3,
    input  logic            id_funct7b5,
    input  logic            flush,
    input  logic            hold,
    output logic            stall,
    output logic            ex_valid,
    output logic            ex_alusrc,
    output logic            ex_memtoreg,
    output logic            ex_regwrite,
    output logic            ex_memread,
    output logic            ex_memwrite,
    output logic            ex_branch,
    output logic            ex_aluop1,
    output logic            ex_aluop0,
    output logic [XLEN-1:0] ex_pc,
    output logic [XLEN-1:0] ex_rs1_data,
    output logic [XLEN-1:0] ex_rs2_data,
    output logic [XLEN-1:0] ex_imm,
    output logic [RAW-1:0]  ex_rs1,
    output logic [RAW-1:0]  ex_rs2,
    output logic [RAW-1:0]  ex_rd,
    output logic [2:0]      ex_funct3,
    output logic            ex_funct7b5
`ifdef ID_EX_PERF_CNT_EN
    ,
    output logic [31:0]     bubble_cnt
`endif
);

    // Control bit order: alusrc, memtoreg, regwrite, memread, memwrite, branch, aluop1, aluop0
    logic            r_valid;
    logic [7:0]      r_ctrl;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_rs1_data;
    logic [XLEN-1:0] r_rs2_data;
    logic [XLEN-1:0] r_imm;
    logic [RAW-1:0]  r_rs1;
    logic [RAW-1:0]  r_rs2;
    logic [RAW-1:0]  r_rd;
    logic [2:0]      r_funct3;
    logic            r_funct7b5;

    logic [7:0] w_id_ctrl;
    logic       w_uses_rs2;
    logic       w_hazard;
    logic       w_bubble;

    assign w_id_ctrl  = {id_alusrc, id_memtoreg, id_regwrite, id_memread,
                         id_memwrite, id_branch, id_aluop1, id_aluop0};
    assign w_uses_rs2 = ~id_alusrc | id_memwrite;

    // Load in EX whose destination feeds the instruction now in decode.
    assign w_hazard = r_valid & r_ctrl[4] & (r_rd != '0) & id_valid &
                      ((id_rs1 == r_rd) | (w_uses_rs2 & (id_rs2 == r_rd)));

    assign stall    = (w_hazard | hold) & ~flush;
    assign w_bubble = flush | (~hold & w_hazard);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid    <= 1'b0;
            r_ctrl     <= '0;
            r_pc       <= '0;
            r_rs1_data <= '0;
            r_rs2_data <= '0;
            r_imm      <= '0;
            r_rs1      <= '0;
            r_rs2      <= '0;
            r_rd       <= '0;
            r_funct3   <= '0;
            r_funct7b5 <= 1'b0;
        end else if (w_bubble) begin
            r_valid    <= 1'b0;
            r_ctrl     <= '0;
            r_pc       <= '0;
            r_rs1_data <= '0;
            r_rs2_data <= '0;
            r_imm      <= '0;
            r_rs1      <= '0;
            r_rs2      <= '0;
            r_rd       <= '0;
            r_funct3   <= '0;
            r_funct7b5 <= 1'b0;
        end else if (!hold) begin
            r_valid    <= id_valid;
            r_ctrl     <= id_valid ? w_id_ctrl : 8'h00;
            r_pc       <= id_pc;
            r_rs1_data <= id_rs1_data;
            r_rs2_data <= id_rs2_data;
            r_imm      <= id_imm;
            r_rs1      <= id_rs1;
            r_rs2      <= id_rs2;
            r_rd       <= id_rd;
            r_funct3   <= id_funct3;
            r_funct7b5 <= id_funct7b5;
        end
    end

`ifdef ID_EX_PERF_CNT_EN
    logic [31:0] r_bubble_cnt;

    // Only hazard bubbles count; flush bubbles and held cycles do not.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bubble_cnt <= '0;
        end else if (!flush && !hold && w_hazard) begin
            r_bubble_cnt <= r_bubble_cnt + 32'd1;
        end
    end

    assign bubble_cnt = r_bubble_cnt;
`endif

    assign ex_valid    = r_valid;
    assign ex_alusrc   = r_ctrl[7];
    assign ex_memtoreg = r_ctrl[6];
    assign ex_regwrite = r_ctrl[5];
    assign ex_memread  = r_ctrl[4];
    assign ex_memwrite = r_ctrl[3];
    assign ex_branch   = r_ctrl[2];
    assign ex_aluop1   = r_ctrl[1];
    assign ex_aluop0   = r_ctrl[0];
    assign ex_pc       = r_pc;
    assign ex_rs1_data = r_rs1_data;
    assign ex_rs2_data = r_rs2_data;
    assign ex_imm      = r_imm;
    assign ex_rs1      = r_rs1;
    assign ex_rs2      = r_rs2;
    assign ex_rd       = r_rd;
    assign ex_funct3   = r_funct3;
    assign ex_funct7b5 = r_funct7b5;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed hazard/flush/hold scenarios plus random traffic against a
// behavioural model of the stage; bubble_cnt is checked when ID_EX_PERF_CNT_EN is defined.
module tb_id_ex_stage;

    localparam int XLEN = 64;
    localparam int RAW  = 5;

    // Decoder control words: {alusrc, memtoreg, regwrite, memread, memwrite, branch, aluop1, aluop0}
    localparam logic [7:0] C_RTYPE = 8'b0010_0010;
    localparam logic [7:0] C_LD    = 8'b1111_0000;
    localparam logic [7:0] C_SD    = 8'b1000_1000;
    localparam logic [7:0] C_BEQ   = 8'b0000_0101;
    localparam logic [7:0] C_ADDI  = 8'b1010_0000;

    logic            clk;
    logic            rst_n;
    logic            id_valid;
    logic            id_alusrc, id_memtoreg, id_regwrite, id_memread;
    logic            id_memwrite, id_branch, id_aluop1, id_aluop0;
    logic [XLEN-1:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
    logic [RAW-1:0]  id_rs1, id_rs2, id_rd;
    logic [2:0]      id_funct3;
    logic            id_funct7b5;
    logic            flush, hold;
    logic            stall, ex_valid;
    logic            ex_alusrc, ex_memtoreg, ex_regwrite, ex_memread;
    logic            ex_memwrite, ex_branch, ex_aluop1, ex_aluop0;
    logic [XLEN-1:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
    logic [RAW-1:0]  ex_rs1, ex_rs2, ex_rd;
    logic [2:0]      ex_funct3;
    logic            ex_funct7b5;
`ifdef ID_EX_PERF_CNT_EN
    logic [31:0]     bubble_cnt;
`endif

    id_ex_stage #(.XLEN(XLEN), .RAW(RAW)) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
        .id_alusrc(id_alusrc), .id_memtoreg(id_memtoreg), .id_regwrite(id_regwrite),
        .id_memread(id_memread), .id_memwrite(id_memwrite), .id_branch(id_branch),
        .id_aluop1(id_aluop1), .id_aluop0(id_aluop0),
        .id_pc(id_pc), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_funct3(id_funct3), .id_funct7b5(id_funct7b5),
        .flush(flush), .hold(hold), .stall(stall), .ex_valid(ex_valid),
        .ex_alusrc(ex_alusrc), .ex_memtoreg(ex_memtoreg), .ex_regwrite(ex_regwrite),
        .ex_memread(ex_memread), .ex_memwrite(ex_memwrite), .ex_branch(ex_branch),
        .ex_aluop1(ex_aluop1), .ex_aluop0(ex_aluop0),
        .ex_pc(ex_pc), .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
        .ex_funct3(ex_funct3), .ex_funct7b5(ex_funct7b5)
`ifdef ID_EX_PERF_CNT_EN
        , .bubble_cnt(bubble_cnt)
`endif
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL timeout: bench did not finish within the time limit");
        $fatal(1, "timeout");
    end

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_fail   = 0;
    logic [63:0] exp_q[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Model of what the EX register should hold, described as an instruction slot.
    logic            m_valid;
    logic [7:0]      m_ctrl;
    logic [XLEN-1:0] m_pc, m_rs1d, m_rs2d, m_imm;
    logic [RAW-1:0]  m_rs1, m_rs2, m_rd;
    logic [2:0]      m_f3;
    logic            m_f7;
    logic [31:0]     m_cnt;

    task automatic model_clear();
        m_valid = 1'b0; m_ctrl = '0; m_pc = '0; m_rs1d = '0; m_rs2d = '0; m_imm = '0;
        m_rs1 = '0; m_rs2 = '0; m_rd = '0; m_f3 = '0; m_f7 = 1'b0;
    endtask

    // Does the decode instruction read the destination of a load sitting in EX?
    function automatic logic model_hazard();
        logic reads_rs2;
        logic is_load;
        reads_rs2 = (id_alusrc == 1'b0) || id_memwrite;
        is_load   = m_valid && m_ctrl[4];
        if (!is_load || m_rd == 0 || !id_valid) return 1'b0;
        return (id_rs1 == m_rd) || (reads_rs2 && id_rs2 == m_rd);
    endfunction

    task automatic check_ex(input string tag);
        exp_q.push_back({55'd0, m_valid, m_ctrl});
        exp_q.push_back(m_pc);
        exp_q.push_back(m_rs1d);
        exp_q.push_back(m_rs2d);
        exp_q.push_back(m_imm);
        exp_q.push_back({45'd0, m_rs1, m_rs2, m_rd, m_f3, m_f7});
        check({tag, "_ctrl"}, {55'd0, ex_valid, ex_alusrc, ex_memtoreg, ex_regwrite, ex_memread,
              ex_memwrite, ex_branch, ex_aluop1, ex_aluop0}, exp_q.pop_front());
        check({tag, "_pc"},   ex_pc,       exp_q.pop_front());
        check({tag, "_rs1d"}, ex_rs1_data, exp_q.pop_front());
        check({tag, "_rs2d"}, ex_rs2_data, exp_q.pop_front());
        check({tag, "_imm"},  ex_imm,      exp_q.pop_front());
        check({tag, "_idx"},  {45'd0, ex_rs1, ex_rs2, ex_rd, ex_funct3, ex_funct7b5},
              exp_q.pop_front());
`ifdef ID_EX_PERF_CNT_EN
        check({tag, "_cnt"}, {32'd0, bubble_cnt}, {32'd0, m_cnt});
`endif
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive_id(input logic v, input logic [7:0] c, input logic [XLEN-1:0] pc,
                            input logic [XLEN-1:0] d1, input logic [XLEN-1:0] d2,
                            input logic [XLEN-1:0] imm, input logic [RAW-1:0] rs1,
                            input logic [RAW-1:0] rs2, input logic [RAW-1:0] rd,
                            input logic [2:0] f3, input logic f7);
        id_valid = v;
        {id_alusrc, id_memtoreg, id_regwrite, id_memread,
         id_memwrite, id_branch, id_aluop1, id_aluop0} = c;
        id_pc = pc; id_rs1_data = d1; id_rs2_data = d2; id_imm = imm;
        id_rs1 = rs1; id_rs2 = rs2; id_rd = rd; id_funct3 = f3; id_funct7b5 = f7;
    endtask

    task automatic drive_instr(input logic [7:0] c, input logic [RAW-1:0] rs1,
                               input logic [RAW-1:0] rs2, input logic [RAW-1:0] rd);
        drive_id(1'b1, c, {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom},
                 {$urandom, $urandom}, rs1, rs2, rd, 3'($urandom_range(0, 7)),
                 1'($urandom_range(0, 1)));
    endtask

    // Called just after a falling edge with inputs driven: checks stall, clocks, checks EX.
    task automatic cycle(input string tag);
        logic hz;
        #1;
        hz = model_hazard();
        check({tag, "_stall"}, {63'd0, stall}, {63'd0, (hz || hold) && !flush});
        @(posedge clk);
        if (flush) begin
            model_clear();
        end else if (hold) begin
            // slot frozen
        end else if (hz) begin
            model_clear();
            m_cnt = m_cnt + 32'd1;
        end else begin
            m_valid = id_valid;
            m_ctrl  = id_valid ? {id_alusrc, id_memtoreg, id_regwrite, id_memread,
                                  id_memwrite, id_branch, id_aluop1, id_aluop0} : 8'h00;
            m_pc = id_pc; m_rs1d = id_rs1_data; m_rs2d = id_rs2_data; m_imm = id_imm;
            m_rs1 = id_rs1; m_rs2 = id_rs2; m_rd = id_rd; m_f3 = id_funct3; m_f7 = id_funct7b5;
        end
        #1;
        check_ex(tag);
        @(negedge clk);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [7:0] kinds [5];
        kinds[0] = C_RTYPE; kinds[1] = C_LD; kinds[2] = C_SD; kinds[3] = C_BEQ; kinds[4] = C_ADDI;
        rst_n = 1'b0; flush = 1'b0; hold = 1'b0; m_cnt = '0;
        model_clear();
        drive_id(1'b0, 8'h00, '0, '0, '0, '0, '0, '0, '0, '0, 1'b0);
        repeat (2) @(negedge clk);
        check_ex("reset");
        rst_n = 1'b1;

        // Pass-through of an R-type instruction.
        drive_id(1'b1, C_RTYPE, 64'h100, 64'h1234, 64'h55, 64'h0, 5'd1, 5'd2, 5'd5, 3'd0, 1'b0);
        cycle("pass");
        check("pass_rd", {59'd0, ex_rd}, 64'd5);
        check("pass_rs1d", ex_rs1_data, 64'h1234);

        // Load-use: ld x7 then add using x7 as rs2 -> one bubble, then add enters.
        drive_instr(C_LD, 5'd1, 5'd0, 5'd7);
        cycle("ld7");
        drive_instr(C_RTYPE, 5'd2, 5'd7, 5'd8);
        cycle("lu_bubble");
        check("lu_bubble_valid", {63'd0, ex_valid}, 64'd0);
        cycle("lu_enter");
        check("lu_enter_rs2", {59'd0, ex_rs2}, 64'd7);

        // rd = x0 never hazards.
        drive_instr(C_LD, 5'd1, 5'd0, 5'd0);
        cycle("ld0");
        drive_instr(C_RTYPE, 5'd0, 5'd4, 5'd9);
        cycle("x0_add");

        // sd reads rs2 through memwrite.
        drive_instr(C_LD, 5'd1, 5'd0, 5'd3);
        cycle("ld3a");
        drive_instr(C_SD, 5'd4, 5'd3, 5'd0);
        cycle("sd_bubble");
        cycle("sd_enter");

        // ld ignores rs2 (alusrc=1, no memwrite).
        drive_instr(C_LD, 5'd1, 5'd0, 5'd3);
        cycle("ld3b");
        drive_instr(C_LD, 5'd4, 5'd3, 5'd6);
        cycle("ld_rs2");

        // Flush together with hazard: flush wins.
        drive_instr(C_LD, 5'd1, 5'd0, 5'd7);
        cycle("ld7b");
        drive_instr(C_RTYPE, 5'd7, 5'd2, 5'd8);
        flush = 1'b1;
        cycle("flush_hz");
        flush = 1'b0;

        // Hold for three cycles freezes EX and stalls.
        drive_instr(C_ADDI, 5'd2, 5'd0, 5'd10);
        cycle("pre_hold");
        drive_instr(C_RTYPE, 5'd3, 5'd4, 5'd11);
        hold = 1'b1;
        for (int i = 0; i < 3; i++) cycle("hold");
        hold = 1'b0;
        cycle("post_hold");

`ifdef ID_EX_PERF_CNT_EN
        // Counter wrap from all ones.
        force dut.r_bubble_cnt = 32'hFFFF_FFFF;
        #1;
        release dut.r_bubble_cnt;
        m_cnt = 32'hFFFF_FFFF;
        drive_instr(C_LD, 5'd1, 5'd0, 5'd7);
        cycle("wrap_ld");
        drive_instr(C_RTYPE, 5'd7, 5'd7, 5'd8);
        cycle("wrap_bubble");
        check("wrap_zero", {32'd0, bubble_cnt}, 64'd0);
        cycle("wrap_enter");
`endif

        // Random traffic over a small register pool to provoke hazards.
        for (int n = 0; n < 400; n++) begin
            drive_id(1'($urandom_range(0, 7) != 0), kinds[$urandom_range(0, 4)],
                     {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom},
                     {$urandom, $urandom}, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                     5'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
                     1'($urandom_range(0, 1)));
            flush = ($urandom_range(0, 7) == 0);
            hold  = ($urandom_range(0, 5) == 0);
            cycle("rand");
        end
        flush = 1'b0; hold = 1'b0;

        // Reset asserted in the middle of a load-use stall.
        drive_instr(C_LD, 5'd1, 5'd0, 5'd7);
        cycle("rst_ld");
        drive_instr(C_RTYPE, 5'd7, 5'd1, 5'd8);
        flush = 1'b1; hold = 1'b1;
        #1;
        check("pre_rst_stall", {63'd0, stall}, 64'd0);
        flush = 1'b0; hold = 1'b0;
        #1;
        check("pre_rst_stall_hz", {63'd0, stall}, 64'd1);
        rst_n = 1'b0;
        #1;
        model_clear();
        m_cnt = '0;
        check_ex("rst_mid");
        check("rst_mid_stall", {63'd0, stall}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        cycle("after_rst");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- Pipeline register between decode (opcode control decoder plus register file read) and execute in the 64-bit RISC-V datapath.
- Latches decoded control bits, operands and register indices each cycle.
- Detects load-use hazards, stalls the front end and inserts a bubble.
- Squashes its contents on a taken-branch flush.

Parameters:
- XLEN, 64, data/PC/immediate width.
- RAW, 5, register index width.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- id_valid  in  1  decode stage holds a real instruction.
- id_alusrc, id_memtoreg, id_regwrite, id_memread, id_memwrite, id_branch, id_aluop1, id_aluop0  in  1 each  decoder control bits.
- id_pc  in  XLEN  instruction PC.
- id_rs1_data, id_rs2_data, id_imm  in  XLEN  operands and sign-extended immediate.
- id_rs1, id_rs2, id_rd  in  RAW  register indices.
- id_funct3  in  3  instruction funct3.
- id_funct7b5  in  1  instruction bit 30.
- flush  in  1  taken branch resolved downstream; kill the decode-stage instruction.
- hold  in  1  downstream freeze (memory wait).
- stall  out  1  freeze PC and IF/ID this cycle.
- ex_valid  out  1  ex_* contents are a real instruction.
- ex_alusrc, ex_memtoreg, ex_regwrite, ex_memread, ex_memwrite, ex_branch, ex_aluop1, ex_aluop0  out  1 each  registered control bits.
- ex_pc, ex_rs1_data, ex_rs2_data, ex_imm  out  XLEN  registered operands.
- ex_rs1, ex_rs2, ex_rd  out  RAW  registered indices.
- ex_funct3  out  3  registered funct3.
- ex_funct7b5  out  1  registered bit 30.

Behaviour:
- Reset (rst_n low, asynchronous): every ex_* output is 0, including ex_valid. stall follows its combinational equation from the reset register values.
- Latency: 1 cycle from id_* to ex_*.
- uses_rs2 = (id_alusrc == 0) or id_memwrite. Covers R-type, beq and sd.
- hazard (combinational) = ex_valid and ex_memread and ex_rd != 0 and id_valid and (id_rs1 == ex_rd or (uses_rs2 and id_rs2 == ex_rd)).
- stall = (hazard or hold) and not flush.
- Per rising edge, in priority order:
  1. flush=1: load a bubble. ex_valid=0 and all eight ex control bits 0; data fields are don't-care and are driven to 0.
  2. else hold=1: all ex_* retain their values.
  3. else hazard=1: load a bubble, same as case 1.
  4. else: load id_*; ex_valid=id_valid. If id_valid=0, the control bits are forced to 0.
- A bubble never asserts ex_regwrite, ex_memwrite, ex_memread or ex_branch.
- A hazard lasts exactly one cycle for a single load. After the bubble, ex_memread=0, so hazard deasserts and the held instruction enters.
- rd = x0 never causes a hazard.
- flush together with hazard: flush wins and stall=0. The front end is redirected, so the hazard is discarded.
- Reset mid-stall: all registers clear immediately and stall drops because ex_valid=0.

Optional Feature:
- Macro ID_EX_PERF_CNT_EN.
- When defined:
  - adds output bubble_cnt, 32 bits.
  - Counter resets to 0 and increments by 1 on each edge where case 3 (hazard bubble) applies.
  - Flush bubbles are not counted.
  - Wraps from 0xFFFFFFFF to 0.
  - Holds while hold=1.
- When undefined: the port and counter are absent, and behaviour is otherwise identical.

Test Plan:
- Reset: drive all inputs nonzero, pulse rst_n low mid-cycle -> all ex_* read 0 immediately with no clock edge.
- Pass-through: id_valid=1, R-type controls (regwrite=1, aluop1=1), id_rd=5, id_rs1_data=0x1234 -> next edge ex_valid=1, ex_regwrite=1, ex_aluop1=1, ex_rd=5, ex_rs1_data=0x1234; stall=0.
- Load-use: ld with rd=7 in EX, next instruction add with rs2=7 -> stall=1 for one cycle, one bubble (ex_valid=0, ex_regwrite=0), then add enters with ex_rs2=7.
- x0 and sd cases:
  - ld rd=0 followed by add rs1=0 -> stall stays 0.
  - ld rd=3 followed by sd rs2=3 -> stall=1 (rs2 used).
  - ld rd=3 followed by ld rs2=3 (alusrc=1) -> stall=0.
- Priority: hazard and flush in the same cycle -> stall=0, bubble loaded. hold=1 for 3 cycles -> ex_* frozen and stall=1 for all 3.
- With ID_EX_PERF_CNT_EN: 4 load-use events plus 2 flushes -> bubble_cnt=4. Preload the counter near 0xFFFFFFFF via repeated hazards (or force it) -> one more hazard wraps it to 0.
